// File: rtl/m_fetch_pkg.sv
// Types shared by the fetch stage: the fetched-word record and the fetch FSM states.
package m_fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instruction;
    } s_fetched;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } e_fetch_state;

endpackage

// File: rtl/m_sync_fifo.sv
// Single-clock FIFO with flush; used for the instruction queue and the in-flight address FIFO.
module m_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // NOTE: storage is not reset; the count alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/m_fetch.sv
// Instruction fetch: credit-limited in-order requests, tagged instruction queue, redirect with discard.
module m_fetch
    import m_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req_valid,
    output logic [31:0] mem_req_addr,
    input  logic        mem_req_ready,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);
    localparam int CW = $clog2(QUEUE_DEPTH) + 1;

    e_fetch_state  state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [CW-1:0] occupancy;
    logic [CW-1:0] outstanding;
    logic [CW:0]   credit_used;
    logic          req_fire, rsp_fire;
    logic          q_push, q_pop, q_full, q_empty;
    logic          a_full, a_empty;
    s_fetched      q_wdata, q_rdata;
    logic [31:0]   a_rdata;
    logic          redirect_lsb_unused;

    assign redirect_lsb_unused = ^redirect_pc[1:0];

    // Outstanding requests already own a queue slot, so requests stop once slots are all spoken for.
    assign credit_used   = {1'b0, occupancy} + {1'b0, outstanding};
    assign mem_req_valid = rst_n && !a_full && (credit_used < (CW+1)'(QUEUE_DEPTH));
    assign mem_req_addr  = pc_q;
    assign req_fire      = mem_req_valid && mem_req_ready;
    assign rsp_fire      = mem_rsp_valid && !a_empty;

    assign q_push      = rsp_fire && !redirect_valid && (state_q == RUN) && !q_full;
    assign q_pop       = instr_valid && instr_ready && !redirect_valid;
    assign q_wdata     = '{pc: a_rdata, instruction: mem_rsp_data};
    assign instr_valid = !q_empty;
    assign instruction = q_rdata.instruction;
    assign instr_pc    = q_rdata.pc;

    always_comb begin
        // NOTE: every always_comb target gets a default first so no latch is inferred.
        pc_d      = pc_q;
        discard_d = discard_q;
        state_d   = state_q;
        if (redirect_valid) begin
            // Everything in flight after this edge, including a same-cycle request, is stale.
            pc_d      = {redirect_pc[31:2], 2'b00};
            discard_d = outstanding + CW'(req_fire) - CW'(rsp_fire);
        end else begin
            if (req_fire) pc_d = pc_q + 32'd4;
            if (rsp_fire && (discard_q != '0)) discard_d = discard_q - 1'b1;
        end
        unique case (state_q)
            RUN:     if (discard_d != '0) state_d = DRAIN;
            DRAIN:   if (discard_d == '0) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            discard_q <= '0;
            state_q   <= RUN;
        end else begin
            pc_q      <= pc_d;
            discard_q <= discard_d;
            state_q   <= state_d;
        end
    end

    m_sync_fifo #(
        .WIDTH ($bits(s_fetched)),
        .DEPTH (QUEUE_DEPTH)
    ) u_instr_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (redirect_valid),
        .push_i  (q_push),
        .wdata_i (q_wdata),
        .pop_i   (q_pop),
        .rdata_o (q_rdata),
        .full_o  (q_full),
        .empty_o (q_empty),
        .count_o (occupancy)
    );

    // Never flushed: discarded responses still retire their address entry in order.
    m_sync_fifo #(
        .WIDTH (32),
        .DEPTH (QUEUE_DEPTH)
    ) u_addr_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (1'b0),
        .push_i  (req_fire),
        .wdata_i (pc_q),
        .pop_i   (rsp_fire),
        .rdata_o (a_rdata),
        .full_o  (a_full),
        .empty_o (a_empty),
        .count_o (outstanding)
    );

endmodule
